// File: rtl/wt_mem_req_arbiter.sv
// wt_mem_req_arbiter
//   Merges the icache miss stream and the dcache memory request stream onto a
//   single registered valid/grant memory channel. It also routes each return
//   back to the cache that issued it and caps the number of in-flight
//   transactions per cache.
//
//   Ports
//     clk_i, rst_i                 clock, synchronous active-high reset
//     icache_*                     icache req/ack handshake plus request fields
//     dcache_*                     dcache req/ack handshake plus request fields
//     mem_req_o / mem_gnt_i        output register valid / downstream accept
//     mem_paddr_o .. mem_tid_o     registered request fields; tid = {src, tid}
//     mem_rtrn_*                   return channel from memory
//     icache_rtrn_vld_o,
//     dcache_rtrn_vld_o,
//     rtrn_tid_o, rtrn_data_o      demultiplexed return to the caches
//     idle_o                       no outstanding transactions and output register empty
module wt_mem_req_arbiter #(
  parameter int PlenWidth      = 56,
  parameter int DataWidth      = 64,
  parameter int IdWidth        = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 icache_req_i,
  output logic                 icache_ack_o,
  input  logic [PlenWidth-1:0] icache_paddr_i,
  input  logic                 icache_nc_i,
  input  logic [IdWidth-1:0]   icache_tid_i,
  input  logic                 dcache_req_i,
  output logic                 dcache_ack_o,
  input  logic [PlenWidth-1:0] dcache_paddr_i,
  input  logic                 dcache_we_i,
  input  logic [DataWidth-1:0] dcache_wdata_i,
  input  logic [2:0]           dcache_size_i,
  input  logic                 dcache_nc_i,
  input  logic [IdWidth-1:0]   dcache_tid_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [PlenWidth-1:0] mem_paddr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic                 mem_we_o,
  output logic [2:0]           mem_size_o,
  output logic                 mem_nc_o,
  output logic [IdWidth:0]     mem_tid_o,
  input  logic                 mem_rtrn_vld_i,
  input  logic [IdWidth:0]     mem_rtrn_tid_i,
  input  logic [DataWidth-1:0] mem_rtrn_data_i,
  output logic                 icache_rtrn_vld_o,
  output logic                 dcache_rtrn_vld_o,
  output logic [IdWidth-1:0]   rtrn_tid_o,
  output logic [DataWidth-1:0] rtrn_data_o,
  output logic                 idle_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  // Port index 0 = icache, 1 = dcache throughout.
  logic [1:0] req;
  logic [1:0] ack;
  logic [1:0] rtrn_hit;
  logic [1:0] cnt_ok;    // below the in-flight cap
  logic [1:0] cnt_zero;
  logic [1:0] elig;

  logic                 mem_req_q,   mem_req_d;
  logic [PlenWidth-1:0] mem_paddr_q, mem_paddr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q,    mem_we_d;
  logic [2:0]           mem_size_q,  mem_size_d;
  logic                 mem_nc_q,    mem_nc_d;
  logic [IdWidth:0]     mem_tid_q,   mem_tid_d;
  logic                 last_grant_q, last_grant_d; // 1 = dcache won last capture

  logic free;
  logic capture;
  logic pick_d;

  assign req  = {dcache_req_i, icache_req_i};
  assign elig = req & cnt_ok;

  // The output register can take a new request when empty or when it is being
  // drained in this very cycle, which gives one request per cycle throughput.
  assign free    = mem_req_q & mem_gnt_i;
  assign capture = (~mem_req_q | free) & (|elig) & ~rst_i;

  // Dcache wins when it is the only eligible port, or when both are eligible
  // and the icache won the previous capture.
  assign pick_d = elig[1] & (~elig[0] | ~last_grant_q);

  assign ack[0] = capture & ~pick_d;
  assign ack[1] = capture & pick_d;

  assign icache_ack_o = ack[0];
  assign dcache_ack_o = ack[1];

  // Return demux: the msb of the returned tid names the issuing cache.
  assign icache_rtrn_vld_o = mem_rtrn_vld_i & ~mem_rtrn_tid_i[IdWidth];
  assign dcache_rtrn_vld_o = mem_rtrn_vld_i &  mem_rtrn_tid_i[IdWidth];
  assign rtrn_tid_o        = mem_rtrn_tid_i[IdWidth-1:0];
  assign rtrn_data_o       = mem_rtrn_data_i;
  assign rtrn_hit          = {dcache_rtrn_vld_o, icache_rtrn_vld_o};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CntW-1:0] cnt_q, cnt_d;

      // Simultaneous issue and return cancel out; a stray return at zero holds.
      always_comb begin
        cnt_d = cnt_q;
        if (ack[gi] && !rtrn_hit[gi]) begin
          cnt_d = cnt_q + CntW'(1);
        end else if (!ack[gi] && rtrn_hit[gi] && (cnt_q != '0)) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_ok[gi]   = (cnt_q < CntW'(MaxOutstanding));
      assign cnt_zero[gi] = (cnt_q == '0);

      a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= CntW'(MaxOutstanding));
      a_no_stray_rtrn: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rtrn_hit[gi] && (cnt_q == '0)));
      a_ack_needs_req: assert property (@(posedge clk_i) disable iff (rst_i)
        ack[gi] |-> req[gi]);
    end
  endgenerate

  always_comb begin
    mem_req_d    = mem_req_q & ~free;
    mem_paddr_d  = mem_paddr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    mem_size_d   = mem_size_q;
    mem_nc_d     = mem_nc_q;
    mem_tid_d    = mem_tid_q;
    last_grant_d = last_grant_q;
    if (capture) begin
      mem_req_d    = 1'b1;
      last_grant_d = pick_d;
      if (pick_d) begin
        mem_paddr_d = dcache_paddr_i;
        mem_wdata_d = dcache_wdata_i;
        mem_we_d    = dcache_we_i;
        mem_size_d  = dcache_size_i;
        mem_nc_d    = dcache_nc_i;
        mem_tid_d   = {1'b1, dcache_tid_i};
      end else begin
        // Icache always fetches a full line.
        mem_paddr_d = icache_paddr_i;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        mem_size_d  = 3'b111;
        mem_nc_d    = icache_nc_i;
        mem_tid_d   = {1'b0, icache_tid_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_q    <= 1'b0;
      mem_paddr_q  <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_size_q   <= '0;
      mem_nc_q     <= 1'b0;
      mem_tid_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_paddr_q  <= mem_paddr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_size_q   <= mem_size_d;
      mem_nc_q     <= mem_nc_d;
      mem_tid_q    <= mem_tid_d;
      last_grant_q <= last_grant_d;
    end
  end

  a_stable_backpressure: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_req_q && !mem_gnt_i) |=> (mem_req_q && $stable(mem_paddr_q) && $stable(mem_wdata_q)
      && $stable(mem_we_q) && $stable(mem_size_q) && $stable(mem_nc_q) && $stable(mem_tid_q)));

  assign mem_req_o   = mem_req_q;
  assign mem_paddr_o = mem_paddr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_size_o  = mem_size_q;
  assign mem_nc_o    = mem_nc_q;
  assign mem_tid_o   = mem_tid_q;
  assign idle_o      = ~mem_req_q & (&cnt_zero);

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Testbench for wt_mem_req_arbiter: a table of per-cycle vectors followed by
// hand-written sequences for backpressure and mid-operation reset.
module tb_wt_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, iack, inc;
  logic [55:0] ipaddr;
  logic [1:0]  itid;
  logic        dreq, dack, dwe, dnc;
  logic [55:0] dpaddr;
  logic [63:0] dwdata;
  logic [2:0]  dsize;
  logic [1:0]  dtid;
  logic        mreq, gnt, mwe, mnc;
  logic [55:0] mpaddr;
  logic [63:0] mwdata;
  logic [2:0]  msize;
  logic [2:0]  mtid;
  logic        rvld;
  logic [2:0]  rtid;
  logic [63:0] rdata;
  logic        irv, drv;
  logic [1:0]  rtid_o;
  logic [63:0] rdata_o;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wt_mem_req_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .icache_req_i(ireq), .icache_ack_o(iack), .icache_paddr_i(ipaddr),
    .icache_nc_i(inc), .icache_tid_i(itid),
    .dcache_req_i(dreq), .dcache_ack_o(dack), .dcache_paddr_i(dpaddr),
    .dcache_we_i(dwe), .dcache_wdata_i(dwdata), .dcache_size_i(dsize),
    .dcache_nc_i(dnc), .dcache_tid_i(dtid),
    .mem_req_o(mreq), .mem_gnt_i(gnt), .mem_paddr_o(mpaddr), .mem_wdata_o(mwdata),
    .mem_we_o(mwe), .mem_size_o(msize), .mem_nc_o(mnc), .mem_tid_o(mtid),
    .mem_rtrn_vld_i(rvld), .mem_rtrn_tid_i(rtid), .mem_rtrn_data_i(rdata),
    .icache_rtrn_vld_o(irv), .dcache_rtrn_vld_o(drv),
    .rtrn_tid_o(rtid_o), .rtrn_data_o(rdata_o), .idle_o(idle)
  );

  typedef struct {
    logic       ireq;  logic [1:0] itid;
    logic       dreq;  logic [1:0] dtid;
    logic       gnt;   logic       rvld;  logic [2:0] rtid;
    logic       e_iack; logic e_dack; logic e_mreq; logic [2:0] e_mtid;
    logic       e_idle; logic e_irv;  logic e_drv;  logic [1:0] e_rtid;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic a_ireq, input logic [1:0] a_itid,
                              input logic a_dreq, input logic [1:0] a_dtid,
                              input logic a_gnt, input logic a_rvld, input logic [2:0] a_rtid,
                              input logic x_iack, input logic x_dack, input logic x_mreq,
                              input logic [2:0] x_mtid, input logic x_idle,
                              input logic x_irv, input logic x_drv, input logic [1:0] x_rtid);
    vec_t v;
    v.ireq = a_ireq; v.itid = a_itid; v.dreq = a_dreq; v.dtid = a_dtid;
    v.gnt = a_gnt; v.rvld = a_rvld; v.rtid = a_rtid;
    v.e_iack = x_iack; v.e_dack = x_dack; v.e_mreq = x_mreq; v.e_mtid = x_mtid;
    v.e_idle = x_idle; v.e_irv = x_irv; v.e_drv = x_drv; v.e_rtid = x_rtid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ireq = 0; itid = 0; ipaddr = 0; inc = 0;
    dreq = 0; dtid = 0; dpaddr = 0; dwe = 0; dwdata = 0; dsize = 0; dnc = 0;
    gnt = 1; rvld = 0; rtid = 0; rdata = 0;

    //             ireq itid dreq dtid gnt rvld rtid   iack dack mreq mtid  idle irv drv rtid
    tbl[0]  = mk(0, 0, 0, 0, 1, 0, 3'b000,  0, 0, 0, 3'b000, 1, 0, 0, 0); // reset state
    tbl[1]  = mk(1, 0, 1, 0, 1, 0, 3'b000,  1, 0, 0, 3'b000, 1, 0, 0, 0); // first grant icache
    tbl[2]  = mk(1, 1, 1, 0, 1, 0, 3'b000,  0, 1, 1, 3'b000, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 1, 1, 1, 0, 3'b000,  1, 0, 1, 3'b100, 0, 0, 0, 0);
    tbl[4]  = mk(1, 2, 1, 1, 1, 0, 3'b000,  0, 1, 1, 3'b001, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 3'b000,  0, 0, 1, 3'b101, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 1, 3'b000,  0, 0, 0, 3'b000, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 1, 3'b100,  0, 0, 0, 3'b000, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 1, 1, 3'b001,  0, 0, 0, 3'b000, 0, 1, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 1, 1, 3'b101,  0, 0, 0, 3'b000, 0, 0, 1, 1);
    tbl[10] = mk(1, 3, 0, 0, 1, 0, 3'b000,  1, 0, 0, 3'b000, 1, 0, 0, 0); // single icache req
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 3'b000,  0, 0, 1, 3'b011, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 1, 3'b011,  0, 0, 0, 3'b000, 0, 1, 0, 3);
    tbl[13] = mk(0, 0, 1, 0, 1, 0, 3'b000,  0, 1, 0, 3'b000, 1, 0, 0, 0); // dcache fill to cap
    tbl[14] = mk(0, 0, 1, 1, 1, 0, 3'b000,  0, 1, 1, 3'b100, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 1, 2, 1, 0, 3'b000,  0, 1, 1, 3'b101, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 1, 3, 1, 0, 3'b000,  0, 1, 1, 3'b110, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 1, 0, 1, 0, 3'b000,  0, 0, 1, 3'b111, 0, 0, 0, 0); // 5th held off
    tbl[18] = mk(0, 0, 1, 0, 1, 0, 3'b000,  0, 0, 0, 3'b000, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 1, 0, 1, 1, 3'b100,  0, 0, 0, 3'b000, 0, 0, 1, 0);
    tbl[20] = mk(0, 0, 1, 0, 1, 0, 3'b000,  0, 1, 0, 3'b000, 0, 0, 0, 0); // ack after return
    tbl[21] = mk(0, 0, 0, 0, 1, 1, 3'b101,  0, 0, 1, 3'b100, 0, 0, 1, 1);
    tbl[22] = mk(0, 0, 0, 0, 1, 1, 3'b110,  0, 0, 0, 3'b000, 0, 0, 1, 2);
    tbl[23] = mk(0, 0, 1, 1, 1, 1, 3'b111,  0, 1, 0, 3'b000, 0, 0, 1, 3); // ack+return at cnt 2
    tbl[24] = mk(0, 0, 1, 2, 1, 0, 3'b000,  0, 1, 1, 3'b101, 0, 0, 0, 0);
    tbl[25] = mk(0, 0, 1, 3, 1, 0, 3'b000,  0, 1, 1, 3'b110, 0, 0, 0, 0);
    tbl[26] = mk(0, 0, 1, 0, 1, 0, 3'b000,  0, 0, 1, 3'b111, 0, 0, 0, 0); // cap again
    tbl[27] = mk(0, 0, 0, 0, 1, 1, 3'b100,  0, 0, 0, 3'b000, 0, 0, 1, 0);
    tbl[28] = mk(0, 0, 0, 0, 1, 1, 3'b101,  0, 0, 0, 3'b000, 0, 0, 1, 1);
    tbl[29] = mk(0, 0, 0, 0, 1, 1, 3'b110,  0, 0, 0, 3'b000, 0, 0, 1, 2);
    tbl[30] = mk(0, 0, 0, 0, 1, 1, 3'b111,  0, 0, 0, 3'b000, 0, 0, 1, 3);
    tbl[31] = mk(0, 0, 0, 0, 1, 0, 3'b000,  0, 0, 0, 3'b000, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values of the registered fields.
    #1;
    chk("rst_paddr", 64'(mpaddr), 64'h0);
    chk("rst_tid", 64'(mtid), 64'h0);

    for (int i = 0; i < NV; i++) begin
      ireq = tbl[i].ireq; itid = tbl[i].itid; ipaddr = 56'h1000 + 56'(tbl[i].itid); inc = 1'b0;
      dreq = tbl[i].dreq; dtid = tbl[i].dtid; dpaddr = 56'h2000 + 56'(tbl[i].dtid);
      dwe = 1'b0; dwdata = 64'hD000 + 64'(tbl[i].dtid); dsize = 3'b011; dnc = 1'b0;
      gnt = tbl[i].gnt; rvld = tbl[i].rvld; rtid = tbl[i].rtid; rdata = 64'hABC0 + 64'(tbl[i].rtid);
      #1;
      $display("vec %0d: iack=%0b dack=%0b mreq=%0b mtid=%0b idle=%0b irv=%0b drv=%0b rtid=%0d",
               i, iack, dack, mreq, mtid, idle, irv, drv, rtid_o);
      chk($sformatf("v%0d_iack", i), 64'(iack), 64'(tbl[i].e_iack));
      chk($sformatf("v%0d_dack", i), 64'(dack), 64'(tbl[i].e_dack));
      chk($sformatf("v%0d_mreq", i), 64'(mreq), 64'(tbl[i].e_mreq));
      chk($sformatf("v%0d_idle", i), 64'(idle), 64'(tbl[i].e_idle));
      chk($sformatf("v%0d_irv", i), 64'(irv), 64'(tbl[i].e_irv));
      chk($sformatf("v%0d_drv", i), 64'(drv), 64'(tbl[i].e_drv));
      if (tbl[i].e_mreq) begin
        chk($sformatf("v%0d_mtid", i), 64'(mtid), 64'(tbl[i].e_mtid));
        chk($sformatf("v%0d_mpaddr", i), 64'(mpaddr),
            tbl[i].e_mtid[2] ? 64'h2000 + 64'(tbl[i].e_mtid[1:0]) : 64'h1000 + 64'(tbl[i].e_mtid[1:0]));
        chk($sformatf("v%0d_msize", i), 64'(msize), tbl[i].e_mtid[2] ? 64'h3 : 64'h7);
        chk($sformatf("v%0d_mwdata", i), mwdata,
            tbl[i].e_mtid[2] ? 64'hD000 + 64'(tbl[i].e_mtid[1:0]) : 64'h0);
        chk($sformatf("v%0d_mwe", i), 64'(mwe), 64'h0);
      end
      if (tbl[i].rvld) begin
        chk($sformatf("v%0d_rtid", i), 64'(rtid_o), 64'(tbl[i].e_rtid));
        chk($sformatf("v%0d_rdata", i), rdata_o, 64'hABC0 + 64'(tbl[i].rtid));
      end
      @(negedge clk);
    end
    ireq = 0; dreq = 0; rvld = 0;

    // Backpressure: icache request captured with gnt low, then held for 5 cycles.
    ireq = 1; itid = 1; ipaddr = 56'hAB_CDEF; gnt = 0;
    #1;
    $display("bp capture: iack=%0b", iack);
    chk("bp_iack", 64'(iack), 64'h1);
    @(negedge clk);
    ireq = 0; dreq = 1; dtid = 2; dwe = 1; dwdata = 64'hDEAD_BEEF_0123_4567;
    dsize = 3'b010; dpaddr = 56'h3FF0; dnc = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      $display("bp hold %0d: mreq=%0b dack=%0b paddr=%0h tid=%0b", k, mreq, dack, mpaddr, mtid);
      chk("bp_dack", 64'(dack), 64'h0);
      chk("bp_mreq", 64'(mreq), 64'h1);
      chk("bp_paddr", 64'(mpaddr), 64'hAB_CDEF);
      chk("bp_tid", 64'(mtid), 64'b001);
      chk("bp_size", 64'(msize), 64'h7);
      @(negedge clk);
    end
    gnt = 1;
    #1;
    $display("bp release: dack=%0b mreq=%0b", dack, mreq);
    chk("bp_free_cap_dack", 64'(dack), 64'h1);
    @(negedge clk);
    dreq = 0;
    #1;
    $display("bp next: mreq=%0b paddr=%0h we=%0b tid=%0b", mreq, mpaddr, mwe, mtid);
    chk("bp2_mreq", 64'(mreq), 64'h1);
    chk("bp2_paddr", 64'(mpaddr), 64'h3FF0);
    chk("bp2_we", 64'(mwe), 64'h1);
    chk("bp2_wdata", mwdata, 64'hDEAD_BEEF_0123_4567);
    chk("bp2_size", 64'(msize), 64'h2);
    chk("bp2_nc", 64'(mnc), 64'h1);
    chk("bp2_tid", 64'(mtid), 64'b110);
    @(negedge clk);
    rvld = 1; rtid = 3'b001;
    #1;
    $display("bp rtrn i: irv=%0b rtid=%0d", irv, rtid_o);
    chk("bp_irv", 64'(irv), 64'h1);
    chk("bp_mreq_off", 64'(mreq), 64'h0);
    @(negedge clk);
    rtid = 3'b110;
    #1;
    $display("bp rtrn d: drv=%0b rtid=%0d", drv, rtid_o);
    chk("bp_drv", 64'(drv), 64'h1);
    chk("bp_rtid", 64'(rtid_o), 64'h2);
    @(negedge clk);
    rvld = 0; dwe = 0; dnc = 0;
    #1;
    chk("bp_idle", 64'(idle), 64'h1);

    // Mid-operation reset with the output register full and three icache reads in flight.
    for (int k = 0; k < 3; k++) begin
      ireq = 1; itid = 2'(k); ipaddr = 56'h4000 + 56'(k); gnt = 1;
      #1;
      $display("pre-rst %0d: iack=%0b", k, iack);
      chk("prerst_iack", 64'(iack), 64'h1);
      @(negedge clk);
    end
    ireq = 0; gnt = 0;
    #1;
    chk("prerst_full", 64'(mreq), 64'h1);
    chk("prerst_tid", 64'(mtid), 64'b010);
    @(negedge clk);
    rst = 1; ireq = 1; itid = 0;
    #1;
    $display("in rst: iack=%0b", iack);
    chk("rst_iack", 64'(iack), 64'h0);
    @(negedge clk);
    rst = 0; gnt = 1;
    #1;
    $display("post-rst: mreq=%0b idle=%0b paddr=%0h iack=%0b", mreq, idle, mpaddr, iack);
    chk("postrst_mreq", 64'(mreq), 64'h0);
    chk("postrst_idle", 64'(idle), 64'h1);
    chk("postrst_paddr", 64'(mpaddr), 64'h0);
    chk("postrst_iack0", 64'(iack), 64'h1);
    @(negedge clk);
    // Counter restarted at zero: three more acks fit, then the cap holds the fifth.
    for (int k = 1; k < 5; k++) begin
      #1;
      $display("post-rst req %0d: iack=%0b", k, iack);
      chk($sformatf("postrst_iack%0d", k), 64'(iack), (k < 4) ? 64'h1 : 64'h0);
      @(negedge clk);
    end
    ireq = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
